// File: rtl/pc_fetch_unit.sv
// LEGv8 fetch-stage sequencer: PC register, IF/ID capture, stall/flush/redirect, halt at end of program.
// Optional early unconditional-B redirect in fetch is enabled by defining FETCH_EARLY_B_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PROG_WORDS = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] PC,
    input  logic [31:0] Instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        if_id_pred_taken,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [31:0] PROG_WORDS_W = 32'(PROG_WORDS);

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] if_id_pc_reg;
    logic [31:0] if_id_instr_reg;
    logic        if_id_valid_reg;
    logic        if_id_pred_taken_reg;
    logic        halted_reg;
    logic [15:0] fetch_count_reg;

    logic        out_of_prog;
    logic        take_b;
    logic [31:0] target_aligned;
    logic [31:0] pc_next_seq;

    assign out_of_prog    = (pc_reg >> 2) >= PROG_WORDS_W;
    assign target_aligned = redirect_target & ~32'h3;

`ifdef FETCH_EARLY_B_EN
    logic [31:0] b_offset;
    assign take_b      = (Instruction[31:26] == 6'b000101);
    assign b_offset    = {{4{Instruction[25]}}, Instruction[25:0], 2'b00};
    assign pc_next_seq = take_b ? pc_reg + b_offset : pc_reg + 32'd4;
`else
    assign take_b      = 1'b0;
    assign pc_next_seq = pc_reg + 32'd4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= RUN;
            pc_reg               <= RESET_PC;
            if_id_pc_reg         <= 32'd0;
            if_id_instr_reg      <= 32'd0;
            if_id_valid_reg      <= 1'b0;
            if_id_pred_taken_reg <= 1'b0;
            halted_reg           <= 1'b0;
            fetch_count_reg      <= 16'd0;
        end else if (redirect) begin
            // Redirect also wakes the sequencer from HALT; if_id_pc is left as-is.
            state_reg            <= RUN;
            halted_reg           <= 1'b0;
            pc_reg               <= target_aligned;
            if_id_instr_reg      <= 32'd0;
            if_id_valid_reg      <= 1'b0;
            if_id_pred_taken_reg <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                if_id_instr_reg      <= 32'd0;
                if_id_valid_reg      <= 1'b0;
                if_id_pred_taken_reg <= 1'b0;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    if (out_of_prog) begin
                        state_reg            <= HALT;
                        halted_reg           <= 1'b1;
                        if_id_instr_reg      <= 32'd0;
                        if_id_valid_reg      <= 1'b0;
                        if_id_pred_taken_reg <= 1'b0;
                    end else begin
                        pc_reg               <= pc_next_seq;
                        if_id_pc_reg         <= pc_reg;
                        if_id_instr_reg      <= flush ? 32'd0 : Instruction;
                        if_id_valid_reg      <= ~flush;
                        if_id_pred_taken_reg <= take_b & ~flush;
                        if (!flush && fetch_count_reg != 16'hFFFF)
                            fetch_count_reg <= fetch_count_reg + 16'd1;
                    end
                end
                default: begin
                    if_id_instr_reg      <= 32'd0;
                    if_id_valid_reg      <= 1'b0;
                    if_id_pred_taken_reg <= 1'b0;
                end
            endcase
        end
    end

    assign PC               = pc_reg;
    assign if_id_pc         = if_id_pc_reg;
    assign if_id_instr      = if_id_instr_reg;
    assign if_id_valid      = if_id_valid_reg;
    assign if_id_pred_taken = if_id_pred_taken_reg;
    assign halted           = halted_reg;
    assign fetch_count      = fetch_count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] PC, Instruction, if_id_pc, if_id_instr;
    logic        if_id_valid, if_id_pred_taken, halted;
    logic [15:0] fetch_count;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] prog [0:6] = '{32'hF8400281, 32'h8B010022, 32'hD1000333, 32'hB40000E3,
                                32'h91002294, 32'hF81F4281, 32'h17FFFFFA};

    function automatic logic [31:0] rom(input logic [31:0] addr);
        longint unsigned idx = longint'(addr) / 4;
        return (idx < 7) ? prog[idx] : 32'h0;
    endfunction

    assign Instruction = rom(PC);

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0), .PROG_WORDS(7)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_target(redirect_target), .PC(PC), .Instruction(Instruction),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .if_id_pred_taken(if_id_pred_taken), .halted(halted), .fetch_count(fetch_count)
    );

`ifdef FETCH_EARLY_B_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Reference model: architectural state updated from the priority rules in plain arithmetic.
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid, m_pred, m_halt;
    int          m_cnt;

    task automatic model_step(input bit rs, input bit rd, input bit st, input bit fl, input logic [31:0] tg);
        logic [31:0] w;
        bit          is_b;
        int          off;
        if (rs) begin
            m_pc = 32'h0; m_ipc = 0; m_instr = 0; m_valid = 0; m_pred = 0; m_halt = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc = (tg / 4) * 4; m_instr = 0; m_valid = 0; m_pred = 0; m_halt = 0;
        end else if (st) begin
            if (fl) begin m_instr = 0; m_valid = 0; m_pred = 0; end
        end else if (m_halt) begin
            m_instr = 0; m_valid = 0; m_pred = 0;
        end else if (longint'(m_pc) / 4 >= 7) begin
            m_halt = 1; m_instr = 0; m_valid = 0; m_pred = 0;
        end else begin
            w    = prog[m_pc / 4];
            is_b = EARLY && (w >> 26) == 5;
            off  = $signed({w[25:0], 2'b00});
            m_ipc   = m_pc;
            m_valid = !fl;
            m_instr = fl ? 32'h0 : w;
            m_pred  = is_b && !fl;
            if (!fl && m_cnt < 65535) m_cnt++;
            m_pc = is_b ? m_pc + 32'(off) : m_pc + 4;
        end
    endtask

    task automatic tick(input bit rs, input bit rd, input bit st, input bit fl, input logic [31:0] tg);
        @(negedge clk);
        reset = rs; redirect = rd; stall = st; flush = fl; redirect_target = tg;
        model_step(rs, rd, st, fl, tg);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        vectors++;
        if (PC !== 32'h0 || if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0 ||
            if_id_instr !== 32'h0 || if_id_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset: PC=%h valid=%b halted=%b cnt=%0d instr=%h pred=%b, required PC=0 others 0",
                     PC, if_id_valid, halted, fetch_count, if_id_instr, if_id_pred_taken);
        end
    endtask

    task automatic test_program_run();
        tick(1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            tick(0, 0, 0, 0, 0);
            vectors++;
            if (PC !== 32'(4 * k) || if_id_pc !== 32'(4 * (k - 1)) || if_id_instr !== prog[k - 1] ||
                if_id_valid !== 1'b1 || halted !== 1'b0) begin
                errors++;
                $display("FAIL run step %0d: PC=%h ipc=%h instr=%h valid=%b halted=%b, required PC=%h ipc=%h instr=%h valid=1 halted=0",
                         k, PC, if_id_pc, if_id_instr, if_id_valid, halted, 4 * k, 4 * (k - 1), prog[k - 1]);
            end
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (halted !== 1'b1 || PC !== 32'd28 || if_id_valid !== 1'b0 || fetch_count !== 16'd7) begin
            errors++;
            $display("FAIL halt entry: halted=%b PC=%h valid=%b cnt=%0d, required halted=1 PC=1c valid=0 cnt=7",
                     halted, PC, if_id_valid, fetch_count);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (halted !== 1'b1 || PC !== 32'd28) begin
            errors++;
            $display("FAIL halt hold: halted=%b PC=%h, required halted=1 PC=1c", halted, PC);
        end
    endtask

    task automatic test_stall();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 1, 0, 0);
            vectors++;
            if (PC !== 32'd8 || if_id_pc !== 32'd4 || if_id_instr !== 32'h8B010022 ||
                if_id_valid !== 1'b1 || fetch_count !== 16'd2) begin
                errors++;
                $display("FAIL stall cycle %0d: PC=%h ipc=%h instr=%h valid=%b cnt=%0d, required PC=8 ipc=4 instr=8b010022 valid=1 cnt=2",
                         k, PC, if_id_pc, if_id_instr, if_id_valid, fetch_count);
            end
        end
    endtask

    task automatic test_redirect_over_stall();
        tick(0, 1, 1, 0, 32'h13);
        vectors++;
        if (PC !== 32'h10 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL redirect: PC=%h valid=%b instr=%h, required PC=10 valid=0 instr=0",
                     PC, if_id_valid, if_id_instr);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (if_id_instr !== 32'h91002294 || if_id_valid !== 1'b1 || PC !== 32'h14) begin
            errors++;
            $display("FAIL redirect target fetch: instr=%h valid=%b PC=%h, required instr=91002294 valid=1 PC=14",
                     if_id_instr, if_id_valid, PC);
        end
    endtask

    task automatic test_flush();
        tick(1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        vectors++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || PC !== 32'd16 || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL flush: valid=%b instr=%h PC=%h cnt=%0d, required valid=0 instr=0 PC=10 cnt=3",
                     if_id_valid, if_id_instr, PC, fetch_count);
        end
        tick(0, 0, 1, 1, 0);
        vectors++;
        if (if_id_valid !== 1'b0 || PC !== 32'd16) begin
            errors++;
            $display("FAIL stall+flush: valid=%b PC=%h, required valid=0 PC=10", if_id_valid, PC);
        end
    endtask

    task automatic test_halt_reset();
        tick(1, 0, 0, 0, 0);
        repeat (9) tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        vectors++;
        if (PC !== 32'h0 || halted !== 1'b0 || fetch_count !== 16'd0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset from halt: PC=%h halted=%b cnt=%0d valid=%b, required PC=0 halted=0 cnt=0 valid=0",
                     PC, halted, fetch_count, if_id_valid);
        end
    endtask

    task automatic test_early_b();
        bit saw_halt = 0;
        tick(1, 0, 0, 0, 0);
        repeat (6) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (EARLY) begin
            if (PC !== 32'h0 || if_id_pred_taken !== 1'b1 || if_id_instr !== 32'h17FFFFFA) begin
                errors++;
                $display("FAIL early B: PC=%h pred=%b instr=%h, required PC=0 pred=1 instr=17fffffa",
                         PC, if_id_pred_taken, if_id_instr);
            end
        end else if (PC !== 32'd28 || if_id_pred_taken !== 1'b0 || if_id_instr !== 32'h17FFFFFA) begin
            errors++;
            $display("FAIL B as plain instr: PC=%h pred=%b instr=%h, required PC=1c pred=0 instr=17fffffa",
                     PC, if_id_pred_taken, if_id_instr);
        end
        repeat (20) begin
            tick(0, 0, 0, 0, 0);
            if (halted === 1'b1) saw_halt = 1;
        end
        vectors++;
        if (saw_halt !== !EARLY) begin
            errors++;
            $display("FAIL halt behaviour after B: saw_halt=%b, required %b", saw_halt, !EARLY);
        end
    endtask

    task automatic test_random();
        bit          rs, rd, st, fl;
        logic [31:0] tg;
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 63) == 0);
            rd = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 5) == 0);
            tg = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 36));
            tick(rs, rd, st, fl, tg);
            vectors++;
            if (PC !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_instr || if_id_valid !== m_valid ||
                if_id_pred_taken !== m_pred || halted !== m_halt || fetch_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random cycle %0d: PC=%h ipc=%h instr=%h v=%b p=%b h=%b cnt=%0d, required PC=%h ipc=%h instr=%h v=%b p=%b h=%b cnt=%0d",
                         n, PC, if_id_pc, if_id_instr, if_id_valid, if_id_pred_taken, halted, fetch_count,
                         m_pc, m_ipc, m_instr, m_valid, m_pred, m_halt, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        if (!EARLY) test_program_run();
        test_stall();
        test_redirect_over_stall();
        test_flush();
        if (!EARLY) test_halt_reset();
        test_early_b();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage sequencer for the LEGv8 processor. It sits directly upstream of the combinational instruction memory: it owns the program counter, drives `PC` into the memory, and captures the returned 32-bit `Instruction` into the IF/ID pipeline register for the decoder. It handles stall, flush, branch redirect from later stages, and end-of-program halt.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `PROG_WORDS`, default 7: number of valid instruction words. A PC with word index (PC>>2) >= `PROG_WORDS` is out of program.

Ports:
- `clk`: input, 1 bit. The single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `stall`: input, 1 bit. Hold PC and the IF/ID register.
- `flush`: input, 1 bit. Invalidate the IF/ID register.
- `redirect`: input, 1 bit. A later stage resolved a taken branch.
- `redirect_target`: input, 32 bits. Branch target; bits [1:0] are ignored and forced to 0.
- `PC`: output, 32 bits. Current fetch address to the instruction memory.
- `Instruction`: input, 32 bits. Memory data for `PC`, valid in the same cycle.
- `if_id_pc`: output, 32 bits. PC of the captured instruction.
- `if_id_instr`: output, 32 bits. Captured instruction; 0 whenever invalid.
- `if_id_valid`: output, 1 bit. The IF/ID register holds a real instruction.
- `if_id_pred_taken`: output, 1 bit. Fetch already redirected on this instruction (early B).
- `halted`: output, 1 bit. FSM is in HALT.
- `fetch_count`: output, 16 bits. Instructions accepted into IF/ID; saturates at 16'hFFFF.

## Operation
- FSM has two states: RUN and HALT.
  - In RUN, if (PC>>2) >= `PROG_WORDS`, there is no redirect and no stall, the FSM goes to HALT at the next edge.
  - In HALT, PC is held, `if_id_valid` is 0, and `halted` is 1.
  - A `redirect` in HALT returns the FSM to RUN with PC = target.
- Priority at each edge, highest first:
  1. `reset`
  2. `redirect`
  3. `stall`
  4. normal advance
- `reset`: PC = `RESET_PC`; `if_id_pc` = 0; `if_id_instr` = 0; `if_id_valid` = 0; `if_id_pred_taken` = 0; `halted` = 0; `fetch_count` = 0; FSM = RUN. This applies at any time, including mid-stall or in HALT.
- `redirect`: PC = {redirect_target[31:2], 2'b00}. IF/ID is invalidated (valid = 0, instr = 0, pred_taken = 0). Redirect overrides `stall` and `flush`.
- `stall` without redirect: PC and all IF/ID fields are held. `flush` together with `stall` still clears `if_id_valid`, `if_id_instr` and `if_id_pred_taken`, but PC is held.
- Normal advance in RUN with PC in program:
  - IF/ID captures {PC, Instruction}, valid = 1 (valid = 0 if `flush`).
  - PC = PC + 4.
  - `fetch_count` increments when valid is captured as 1.
- Out-of-program PC in RUN: the instruction is not captured; valid = 0.
- Arithmetic is modulo 2^32; PC wrap-around from 32'hFFFF_FFFC to 0 is legal, with no error.

## Timing
- PC is registered. The instruction memory is combinational, so `Instruction` corresponds to the current `PC` within the same cycle.
- Fetch-to-IF/ID latency is 1 cycle: the instruction at PC presented in cycle n appears on the `if_id_*` outputs in cycle n+1.
- Redirect penalty: the target instruction reaches IF/ID 2 edges after `redirect` is sampled high. One bubble is inserted.
- `halted` rises 1 cycle after PC leaves program range.
- All outputs come directly from registers; there are no combinational input-to-output paths.

## Configuration
- `FETCH_EARLY_B_EN` defined:
  - In RUN, with no redirect and no stall, if Instruction[31:26] == 6'b000101 (unconditional B), next PC = PC + {{4{Instruction[25]}}, Instruction[25:0], 2'b00}.
  - The B is still captured with `if_id_pred_taken` = 1. Downstream must not redirect on a B carrying this flag.
- `FETCH_EARLY_B_EN` undefined:
  - B is treated like any other instruction; next PC = PC + 4.
  - `if_id_pred_taken` is tied to 0.

## Test plan
- Reset, then run with the 7-word program (F8400281, 8B010022, D1000333, B40000E3, 91002294, F81F4281, 17FFFFFA) and the macro off → PC steps 0, 4, …, 24, 28; IF/ID shows each word one cycle later; `halted` = 1 one cycle after PC = 28; `fetch_count` = 7.
- `stall` held for 3 cycles while PC = 8 → PC stays 8; `if_id_pc` = 4 and `if_id_instr` = 8B010022 are held; `fetch_count` does not change.
- `redirect` = 1 with `redirect_target` = 32'h13 while `stall` = 1 → next PC = 32'h10; `if_id_valid` = 0; on the following edge `if_id_instr` = 91002294.
- With the macro on and PC = 24 (17FFFFFA) → next PC = 0 (offset −24); `if_id_pred_taken` = 1 with `if_id_instr` = 17FFFFFA; `halted` never asserts.
- In HALT, assert `reset` → next edge gives PC = `RESET_PC`, `halted` = 0, `fetch_count` = 0, `if_id_valid` = 0.
- `flush` during normal advance at PC = 12 → `if_id_valid` = 0, `if_id_instr` = 0, PC = 16, `fetch_count` unchanged.
